// File: rtl/rv_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module  : rv_instr_encoder_loader
// Purpose : Encodes decoded RV32I instruction descriptors into 32-bit words,
//           buffers them in a small FIFO and writes them sequentially into
//           instruction memory starting at a captured base byte address.
// Ports   : clk, rst_n            - clock, async active-low reset
//           start, base_addr,
//           num_instr             - session control, captured in IDLE
//           in_valid/in_ready,
//           in_class..in_imm      - descriptor handshake and fields
//           mem_we/addr/wdata     - registered instruction-memory write port
//           busy, done, err       - session status
// Revision: 1.0 - initial release
// ============================================================================
module rv_instr_encoder_loader #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_instr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_sub,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]    PTR_ONE   = (PTR_W+1)'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    num_q, acc_q;
  logic [ADDR_W-1:0]   waddr_q;         // address of the next word to write
  logic                err_q;
  logic [31:0]         fifo_q [DEPTH];
  logic [PTR_W:0]      wptr_q, rptr_q;  // MSB is the wrap bit
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;

  logic                fifo_empty, fifo_full;
  logic                push, pop, start_ok;
  logic [31:0]         enc_word;
  logic                enc_illegal;

  // Upper immediate bits beyond any format's reach are deliberately ignored.
  logic w_unused_imm;
  assign w_unused_imm = &{1'b0, in_imm[31:21]};

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                      (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);

  // Descriptor -> instruction word
  always_comb begin
    enc_word    = 32'h0000_0013;
    enc_illegal = 1'b0;
    case (in_class)
      3'd0: begin
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        // Shift-immediates carry funct7 in the upper immediate slot
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
          enc_word[31:25] = {1'b0, in_sub, 5'b00000};
      end
      3'd1: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
      3'd2: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
      3'd3: enc_word = {1'b0, in_sub, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      3'd4: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], 7'b1100011};
      3'd5: enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
      3'd6: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
      default: begin
        enc_word    = 32'h0000_0013;
        enc_illegal = 1'b1;
      end
    endcase
  end

  // Next-state and handshake/status decode
  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    in_ready = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = (num_instr == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        busy     = 1'b1;
        in_ready = !fifo_full && (acc_q < num_q);
        push     = in_valid && in_ready;
        pop      = !fifo_empty;
        if (acc_q == num_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        pop  = !fifo_empty;
        // Empty here means the final pop happened last cycle, so its
        // registered write is on the port right now.
        if (fifo_empty) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      acc_q       <= '0;
      waddr_q     <= '0;
      err_q       <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q  <= state_d;
      mem_we_q <= pop;
      if (start_ok) begin
        num_q   <= num_instr;
        acc_q   <= '0;
        waddr_q <= base_addr;
        err_q   <= 1'b0;
      end
      if (push) begin
        acc_q  <= acc_q + CNT_ONE;
        wptr_q <= wptr_q + PTR_ONE;
        if (enc_illegal) err_q <= 1'b1;
      end
      if (pop) begin
        mem_wdata_q <= fifo_q[rptr_q[PTR_W-1:0]];
        mem_addr_q  <= waddr_q;
        waddr_q     <= waddr_q + ADDR_STEP;
        rptr_q      <= rptr_q + PTR_ONE;
      end
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q[PTR_W-1:0]] <= enc_word;
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_rv_instr_encoder_loader
// Purpose : Self-checking bench for rv_instr_encoder_loader. Directed program
//           sessions plus randomized descriptor streams are compared against
//           an arithmetic RV32I encoding model and an address/data scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rv_instr_encoder_loader;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  num_instr = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        in_class = '0;
  logic [4:0]        in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]        in_funct3 = '0;
  logic              in_sub = 1'b0;
  logic [31:0]       in_imm = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy, done, err;

  rv_instr_encoder_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_instr(num_instr), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_sub(in_sub), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cls;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        sub;
    logic [31:0] imm;
    logic        has_exp;
    logic [31:0] exp;
  } desc_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  desc_t sess_q[$];
  wr_t   exp_q[$];
  wr_t   mon_e;
  int    wr_cnt = 0, first_wr_cyc = 0, last_wr_cyc = 0, run = 0, max_run = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference encoding: field values placed by plain positional arithmetic.
  function automatic logic [31:0] ref_enc(input desc_t d);
    int unsigned imm, f3, rd, rs1, rs2, sub, top, op;
    imm = d.imm; f3 = d.f3; rd = d.rd; rs1 = d.rs1; rs2 = d.rs2; sub = d.sub;
    case (d.cls)
      3'd0, 3'd1, 3'd5: begin
        op  = (d.cls == 3'd0) ? 19 : (d.cls == 3'd1) ? 3 : 103;
        if (d.cls == 3'd5) f3 = 0;
        top = imm % 4096;
        if (d.cls == 3'd0 && (f3 == 1 || f3 == 5)) top = (imm % 32) + sub * 1024;
        return op + rd * 128 + f3 * 4096 + rs1 * 32768 + top * (1 << 20);
      end
      3'd2: return 35 + (imm % 32) * 128 + f3 * 4096 + rs1 * 32768 + rs2 * (1 << 20)
                   + ((imm >> 5) % 128) * (1 << 25);
      3'd3: return 51 + rd * 128 + f3 * 4096 + rs1 * 32768 + rs2 * (1 << 20) + sub * (1 << 30);
      3'd4: return 99 + ((imm >> 11) & 1) * 128 + ((imm >> 1) % 16) * 256 + f3 * 4096
                   + rs1 * 32768 + rs2 * (1 << 20) + ((imm >> 5) % 64) * (1 << 25)
                   + ((imm >> 12) & 1) * 32'h8000_0000;
      3'd6: return 111 + rd * 128 + ((imm >> 12) % 256) * 4096 + ((imm >> 11) & 1) * (1 << 20)
                   + ((imm >> 1) % 1024) * (1 << 21) + ((imm >> 20) & 1) * 32'h8000_0000;
      default: return 32'h0000_0013;
    endcase
  endfunction

  function automatic desc_t mk(input int cls, input int rd, input int rs1, input int rs2,
                               input int f3, input int sub, input logic [31:0] imm,
                               input logic [31:0] ex);
    desc_t d;
    d.cls = 3'(cls); d.rd = 5'(rd); d.rs1 = 5'(rs1); d.rs2 = 5'(rs2);
    d.f3 = 3'(f3); d.sub = 1'(sub); d.imm = imm; d.has_exp = 1'b1; d.exp = ex;
    return d;
  endfunction

  function automatic desc_t rand_desc();
    desc_t d;
    d.cls = 3'($urandom_range(0, 7)); d.rd = 5'($urandom); d.rs1 = 5'($urandom);
    d.rs2 = 5'($urandom); d.f3 = 3'($urandom); d.sub = 1'($urandom);
    d.imm = $urandom; d.has_exp = 1'b0; d.exp = '0;
    return d;
  endfunction

  task automatic drive(input desc_t d);
    in_class = d.cls; in_rd = d.rd; in_rs1 = d.rs1; in_rs2 = d.rs2;
    in_funct3 = d.f3; in_sub = d.sub; in_imm = d.imm;
  endtask

  task automatic push_exp(input logic [31:0] base, input int idx, input desc_t d);
    wr_t w;
    w.addr = base + 32'(4 * idx);
    w.data = d.has_exp ? d.exp : ref_enc(d);
    exp_q.push_back(w);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        wr_cnt++;
        if (wr_cnt == 1) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        run++;
        if (run > max_run) max_run = run;
        check_eq("write_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check_eq("wr_addr", mem_addr, mon_e.addr);
          check_eq("wr_data", mem_wdata, mon_e.data);
        end
      end else begin
        run = 0;
      end
    end
  end

  task automatic run_session(input logic [31:0] base, input int n, input bit gaps,
                             input bit mid_start, input bit extra_valid);
    int i, guard, acc_cyc0;
    bit exp_err;
    wr_cnt = 0; max_run = 0; run = 0; exp_err = 1'b0; acc_cyc0 = 0;
    @(negedge clk);
    start = 1'b1; base_addr = base; num_instr = 8'(n);
    @(negedge clk);
    start = 1'b0;
    check_eq("err_cleared", 32'(err), 32'd0);
    if (n == 0) begin
      check_eq("done_n0", 32'(done), 32'd1);
      check_eq("busy_n0", 32'(busy), 32'd0);
      @(negedge clk);
      check_eq("done_n0_pulse", 32'(done), 32'd0);
      check_eq("writes_n0", 32'(wr_cnt), 32'd0);
      return;
    end
    check_eq("busy_load", 32'(busy), 32'd1);
    i = 0; guard = 0;
    while (i < n && guard < 1000) begin
      start = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
      end else begin
        drive(sess_q[i]);
        in_valid = 1'b1;
        if (in_ready) begin
          push_exp(base, i, sess_q[i]);
          if (sess_q[i].cls == 3'd7) exp_err = 1'b1;
          if (i == 0) acc_cyc0 = cyc;
          i++;
          if (mid_start && i == n / 2) begin
            start = 1'b1; base_addr = $urandom; num_instr = 8'd1;
          end
        end
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    check_eq("all_accepted", 32'(i), 32'(n));
    guard = 0;
    while (!done && guard < 50) begin
      if (extra_valid) begin
        drive(rand_desc());
        in_valid = 1'b1;
        check_eq("ready_after_n", 32'(in_ready), 32'd0);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    check_eq("done_seen", 32'(done), 32'd1);
    check_eq("n_writes", 32'(wr_cnt), 32'(n));
    check_eq("exp_drained", 32'(exp_q.size()), 32'd0);
    check_eq("done_after_last_wr", 32'(cyc - last_wr_cyc), 32'd1);
    check_eq("first_latency", 32'(first_wr_cyc - acc_cyc0), 32'd2);
    check_eq("err_at_done", 32'(err), 32'(exp_err));
    if (!gaps) check_eq("burst_len", 32'(max_run), 32'(n));
    @(negedge clk);
    check_eq("done_pulse", 32'(done), 32'd0);
    check_eq("err_hold", 32'(err), 32'(exp_err));
    check_eq("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_we"}, 32'(mem_we), 32'd0);
    check_eq({tag, "_addr"}, mem_addr, 32'd0);
    check_eq({tag, "_wdata"}, mem_wdata, 32'd0);
    check_eq({tag, "_ready"}, 32'(in_ready), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic reset_midsession();
    int i, seen, guard;
    sess_q.delete();
    for (int k = 0; k < 5; k++) sess_q.push_back(rand_desc());
    wr_cnt = 0;
    @(negedge clk);
    start = 1'b1; base_addr = 32'h2000; num_instr = 8'd5;
    @(negedge clk);
    start = 1'b0;
    i = 0; seen = 0; guard = 0;
    while (guard < 100) begin
      if (mem_we) seen++;
      if (seen == 2) break;
      if (i < 5) begin
        drive(sess_q[i]);
        in_valid = 1'b1;
        if (in_ready) begin
          push_exp(32'h2000, i, sess_q[i]);
          i++;
        end
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    check_eq("rst_two_writes", 32'(seen), 32'd2);
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    #1 check_reset_outputs("midrst");
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check_eq("midrst_hold_we", 32'(mem_we), 32'd0);
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("post_rst_we", 32'(mem_we), 32'd0);
      check_eq("post_rst_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // addi x1,x0,5
    sess_q.delete();
    sess_q.push_back(mk(0, 1, 0, 0, 0, 0, 32'd5, 32'h0050_0093));
    run_session(32'h100, 1, 1'b0, 1'b0, 1'b0);

    // sub x3,x1,x2 ; sw x2,12(x1)
    sess_q.delete();
    sess_q.push_back(mk(3, 3, 1, 2, 0, 1, 32'd0, 32'h4020_81B3));
    sess_q.push_back(mk(2, 0, 1, 2, 2, 0, 32'd12, 32'h0020_A623));
    run_session(32'h100, 2, 1'b0, 1'b0, 1'b0);

    // bne x1,x0,-8 ; jal x1,8
    sess_q.delete();
    sess_q.push_back(mk(4, 0, 1, 0, 1, 0, 32'hFFFF_FFF8, 32'hFE00_9CE3));
    sess_q.push_back(mk(6, 1, 0, 0, 0, 0, 32'd8, 32'h0080_00EF));
    run_session(32'h100, 2, 1'b0, 1'b0, 1'b0);

    // illegal descriptor in the middle
    sess_q.delete();
    sess_q.push_back(mk(0, 1, 0, 0, 0, 0, 32'd5, 32'h0050_0093));
    sess_q.push_back(mk(7, 9, 9, 9, 5, 1, 32'h1234_5678, 32'h0000_0013));
    sess_q.push_back(mk(3, 5, 1, 2, 0, 0, 32'd0, 32'h0020_82B3));
    run_session(32'h100, 3, 1'b0, 1'b0, 1'b0);

    // 8-word burst, extra valid beyond count, ignored mid-session start
    sess_q.delete();
    for (int k = 0; k < 8; k++) sess_q.push_back(rand_desc());
    run_session(32'h400, 8, 1'b0, 1'b1, 1'b1);

    // empty session
    sess_q.delete();
    run_session(32'h800, 0, 1'b0, 1'b0, 1'b0);

    // address wrap at the top of the space
    sess_q.delete();
    for (int k = 0; k < 4; k++) sess_q.push_back(rand_desc());
    run_session(32'hFFFF_FFF8, 4, 1'b1, 1'b0, 1'b0);

    // randomized sessions
    for (int s = 0; s < 6; s++) begin
      int n;
      n = $urandom_range(1, 12);
      sess_q.delete();
      for (int k = 0; k < n; k++) sess_q.push_back(rand_desc());
      run_session($urandom & 32'hFFFF_FFFC, n, 1'($urandom), 1'b0, 1'($urandom));
    end

    reset_midsession();

    // recovery after abandoned session
    sess_q.delete();
    for (int k = 0; k < 5; k++) sess_q.push_back(rand_desc());
    run_session(32'h3000, 5, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
